mesi_bus_arbiter: RTL and testbench

- Sequences the shared snooping bus for the three MESI L1 processors (P0, P1, P2) and main memory.
- Grants one requester at a time, round-robin, and broadcasts its miss or invalidate message to the other two.
- Collects their snoop responses, orders write-backs and the memory read, and returns the filled block to the requester.
- Sits between the per-processor cache controllers and the memory model; it is the single owner of bus_in and the memory port.

---
 rtl/mesi_bus_arbiter.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_mesi_bus_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mesi_bus_arbiter.sv
// mesi_bus_arbiter
//   Shared snooping-bus sequencer for three MESI L1 controllers and main memory.
//   It grants one requester at a time (round-robin) and broadcasts the requester's
//   message to the snoopers. It then collects the snoop responses, runs the victim
//   and snooper write-backs, reads memory when needed, and returns the filled block
//   with a one-cycle resp_valid pulse.
//
//   Optional build macro: C2C_FWD_EN
//     When defined, a nonzero Modified block supplied by a snooper is forwarded to
//     the requester and the memory read is skipped. The snooper write-back still runs.
//     When undefined, memory is always read after the write-backs.
//
// Ports
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   req[2:0]            per-processor bus request (held until resp_valid)
//   req_msg[47:0]       per-processor message, slice i = [16i+15:16i]
//                       [15:14] type (00 RdMiss, 01 WrMiss, 10 Inv), [13:10] tag
//   wb_req, wb_block    per-processor write-back request / block ([15:12] tag)
//   snoop_done          snooper i finished processing the broadcast
//   has_block           snooper i holds a valid copy
//   snoop_block         snooper i's Modified block (zero otherwise)
//   gnt                 one-hot grant, SNOOP through RESP
//   bus_out             broadcast message (0 when the bus is idle or in RESP)
//   mem_rd/mem_wr       level-held memory requests, finished by mem_ack
//   mem_addr_tag        tag of the current memory access
//   mem_wdata/mem_rdata memory write data / read data
//   resp_valid          one-cycle response pulse to the granted processor
//   resp_block          block delivered to the requester
//   resp_shared         another processor holds the block
//   busy                FSM is not idle
module mesi_bus_arbiter #(
  parameter int NUM_PROC      = 3,
  parameter int SNOOP_TIMEOUT = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_PROC-1:0]     req,
  input  logic [16*NUM_PROC-1:0]  req_msg,
  input  logic [NUM_PROC-1:0]     wb_req,
  input  logic [16*NUM_PROC-1:0]  wb_block,
  input  logic [NUM_PROC-1:0]     snoop_done,
  input  logic [NUM_PROC-1:0]     has_block,
  input  logic [16*NUM_PROC-1:0]  snoop_block,
  output logic [NUM_PROC-1:0]     gnt,
  output logic [15:0]             bus_out,
  output logic                    mem_rd,
  output logic                    mem_wr,
  output logic [3:0]              mem_addr_tag,
  output logic [15:0]             mem_wdata,
  input  logic [15:0]             mem_rdata,
  input  logic                    mem_ack,
  output logic                    resp_valid,
  output logic [15:0]             resp_block,
  output logic                    resp_shared,
  output logic                    busy
);

  localparam int         CNT_W   = $clog2(SNOOP_TIMEOUT + 1);
  localparam logic [1:0] MSG_INV = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_SNOOP, S_WB_VICTIM, S_WB_SNOOP, S_MEM, S_RESP
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            ptr_q, ptr_d;
  logic [NUM_PROC-1:0]   own_q, own_d;
  logic [NUM_PROC-1:0]   done_q, done_d;
  logic [NUM_PROC-1:0]   swb_q, swb_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  vwb_q, vwb_d;
  logic [15:0]           msg_q, msg_d;
  logic [15:0]           vic_q, vic_d;
  logic [15:0]           blk_q, blk_d;
  logic                  shared_q, shared_d;
  logic [16*NUM_PROC-1:0] swblk_q, swblk_d;

  // Round-robin winner: scan from the pointer upward with wrap-around.
  logic                win_vld, win_wb;
  logic [NUM_PROC-1:0] win_oh;
  logic [1:0]          win_nxt;
  logic [15:0]         win_msg, win_vic;

  always_comb begin
    logic [2:0] c;
    win_vld = 1'b0;
    win_oh  = '0;
    win_nxt = 2'd0;
    win_msg = '0;
    win_vic = '0;
    win_wb  = 1'b0;
    c       = '0;
    // Descending scan so the candidate closest to the pointer is assigned last.
    for (int k = NUM_PROC - 1; k >= 0; k--) begin
      c = {1'b0, ptr_q} + 3'(k);
      if (c >= 3'(NUM_PROC)) c = c - 3'(NUM_PROC);
      if (req[c[1:0]]) begin
        win_vld = 1'b1;
        win_oh  = NUM_PROC'(1) << c;
      end
    end
    for (int i = 0; i < NUM_PROC; i++) begin
      if (win_oh[i]) begin
        win_msg = req_msg[16*i +: 16];
        win_vic = wb_block[16*i +: 16];
        win_wb  = wb_req[i];
        win_nxt = (i == NUM_PROC - 1) ? 2'd0 : 2'(i + 1);
      end
    end
  end

  // Snoop bookkeeping. A snooper counts only once it has reported done;
  // the requester's own snoop bits are masked out.
  logic [NUM_PROC-1:0] live, swb_lo;
  logic                snoop_exit, is_inv, mem_after_snoop, mem_after_wb;
  logic [15:0]         sup_blk, swb_data;

  always_comb begin
    live       = (done_q | snoop_done) & ~own_q;
    snoop_exit = (live == ~own_q) || (cnt_q == CNT_W'(SNOOP_TIMEOUT - 1));
    sup_blk    = '0;
    for (int i = NUM_PROC - 1; i >= 0; i--) begin
      if (live[i] && (snoop_block[16*i +: 16] != 16'h0)) sup_blk = snoop_block[16*i +: 16];
    end
    // Snooper write-backs drain lowest index first.
    swb_lo   = swb_q & (~swb_q + NUM_PROC'(1));
    swb_data = '0;
    for (int i = 0; i < NUM_PROC; i++) begin
      if (swb_lo[i]) swb_data = swblk_q[16*i +: 16];
    end
  end

  assign is_inv = (msg_q[15:14] == MSG_INV);

`ifdef C2C_FWD_EN
  // A nonzero supplier block captured into blk_q replaces the memory read.
  assign mem_after_snoop = !is_inv && (sup_blk == 16'h0);
  assign mem_after_wb    = !is_inv && (blk_q == 16'h0);
`else
  assign mem_after_snoop = !is_inv;
  assign mem_after_wb    = !is_inv;
`endif

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    own_d    = own_q;
    done_d   = done_q;
    swb_d    = swb_q;
    cnt_d    = cnt_q;
    vwb_d    = vwb_q;
    msg_d    = msg_q;
    vic_d    = vic_q;
    blk_d    = blk_q;
    shared_d = shared_q;
    swblk_d  = swblk_q;
    unique case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          state_d = S_SNOOP;
          own_d   = win_oh;
          ptr_d   = win_nxt;
          msg_d   = win_msg;
          vic_d   = win_vic;
          vwb_d   = win_wb;
          done_d  = '0;
          cnt_d   = '0;
          swb_d   = '0;
        end
      end
      S_SNOOP: begin
        done_d = live;
        cnt_d  = cnt_q + CNT_W'(1);
        if (snoop_exit) begin
          shared_d = |(has_block & live);
          swb_d    = wb_req & live;
          swblk_d  = wb_block;
          // Under forwarding blk_q keeps the supplier block; otherwise MEM overwrites it.
          blk_d    = is_inv ? 16'h0 : sup_blk;
          if (vwb_q)                          state_d = S_WB_VICTIM;
          else if ((wb_req & live) != '0)     state_d = S_WB_SNOOP;
          else                                state_d = mem_after_snoop ? S_MEM : S_RESP;
        end
      end
      S_WB_VICTIM: begin
        if (mem_ack) begin
          vwb_d = 1'b0;
          if (swb_q != '0) state_d = S_WB_SNOOP;
          else             state_d = mem_after_wb ? S_MEM : S_RESP;
        end
      end
      S_WB_SNOOP: begin
        if (mem_ack) begin
          swb_d = swb_q & ~swb_lo;
          if ((swb_q & ~swb_lo) == '0) state_d = mem_after_wb ? S_MEM : S_RESP;
        end
      end
      S_MEM: begin
        if (mem_ack) begin
          blk_d   = mem_rdata;
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      own_q   <= '0;
      done_q  <= '0;
      swb_q   <= '0;
      cnt_q   <= '0;
      vwb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      done_q  <= done_d;
      swb_q   <= swb_d;
      cnt_q   <= cnt_d;
      vwb_q   <= vwb_d;
    end
  end

  // Transaction payload; only observed through state-gated outputs.
  always_ff @(posedge clock) begin
    msg_q    <= msg_d;
    vic_q    <= vic_d;
    blk_q    <= blk_d;
    shared_q <= shared_d;
    swblk_q  <= swblk_d;
  end

  always_comb begin
    gnt          = '0;
    bus_out      = '0;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr_tag = '0;
    mem_wdata    = '0;
    resp_valid   = 1'b0;
    resp_block   = '0;
    resp_shared  = 1'b0;
    busy         = (state_q != S_IDLE);
    unique case (state_q)
      S_SNOOP: begin
        gnt     = own_q;
        bus_out = msg_q;
      end
      S_WB_VICTIM: begin
        gnt          = own_q;
        bus_out      = msg_q;
        mem_wr       = 1'b1;
        mem_wdata    = vic_q;
        mem_addr_tag = vic_q[15:12];
      end
      S_WB_SNOOP: begin
        gnt          = own_q;
        bus_out      = msg_q;
        mem_wr       = 1'b1;
        mem_wdata    = swb_data;
        mem_addr_tag = swb_data[15:12];
      end
      S_MEM: begin
        gnt          = own_q;
        bus_out      = msg_q;
        mem_rd       = 1'b1;
        mem_addr_tag = msg_q[13:10];
      end
      S_RESP: begin
        gnt         = own_q;
        resp_valid  = 1'b1;
        resp_block  = blk_q;
        resp_shared = shared_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mesi_bus_arbiter.sv
module tb_mesi_bus_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  req, wb_req, snoop_done, has_block, gnt;
  logic [47:0] req_msg, wb_block, snoop_block;
  logic [15:0] bus_out, mem_wdata, mem_rdata, resp_block;
  logic        mem_rd, mem_wr, mem_ack, resp_valid, resp_shared, busy;
  logic [3:0]  mem_addr_tag;

  always #5 clock = ~clock;

  mesi_bus_arbiter #(.NUM_PROC(3), .SNOOP_TIMEOUT(4)) dut (
    .clock(clock), .reset(reset), .req(req), .req_msg(req_msg), .wb_req(wb_req),
    .wb_block(wb_block), .snoop_done(snoop_done), .has_block(has_block),
    .snoop_block(snoop_block), .gnt(gnt), .bus_out(bus_out), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .mem_addr_tag(mem_addr_tag), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .resp_valid(resp_valid),
    .resp_block(resp_block), .resp_shared(resp_shared), .busy(busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Stimulus for one transaction; snoop inputs are held levels.
  logic [2:0]  t_req, t_wbreq, t_done, t_has;
  logic [15:0] t_msg[3], t_wbblk[3], t_sblk[3];
  logic [15:0] t_rdata;
  int          t_delay;

  // Reference model: round-robin pointer plus expected transaction outcome.
  int          m_ptr;
  int          e_win, e_gcyc, e_scyc;
  logic [16:0] e_acc[$];   // {is_read, write data | 12'h0,tag}
  logic [15:0] e_blk;
  logic        e_shared;

  // Observations
  int          o_win, o_gcyc, o_scyc;
  logic [16:0] o_acc[$];
  logic [15:0] o_blk, o_resp_bus, o_snoop_bus;
  logic        o_shared, o_done;
  logic        o_gnt_bad, o_both, o_bus_bad, o_tag_bad, o_idle_bad;

  task automatic clear_stim();
    t_req = 3'b000; t_wbreq = 3'b000; t_done = 3'b111; t_has = 3'b000;
    for (int i = 0; i < 3; i++) begin
      t_msg[i] = 16'h0001; t_wbblk[i] = 16'h0; t_sblk[i] = 16'h0;
    end
    t_rdata = 16'h0; t_delay = 0;
  endtask

  task automatic predict();
    logic [2:0]  live;
    logic [15:0] sup;
    bit          fwd;
    e_win = -1;
    for (int k = 0; k < 3; k++) begin
      int c;
      c = (m_ptr + k) % 3;
      if (e_win < 0 && t_req[c]) e_win = c;
    end
    m_ptr    = (e_win + 1) % 3;
    live     = t_done & ~(3'b001 << e_win);
    e_shared = |(t_has & live);
    e_scyc   = ((live | (3'b001 << e_win)) == 3'b111) ? 1 : 4;
    sup = 16'h0;
    for (int i = 0; i < 3; i++) if (sup == 16'h0 && live[i] && t_sblk[i] != 16'h0) sup = t_sblk[i];
    e_acc.delete();
    if (t_wbreq[e_win]) e_acc.push_back({1'b0, t_wbblk[e_win]});
    for (int i = 0; i < 3; i++) if (live[i] && t_wbreq[i]) e_acc.push_back({1'b0, t_wbblk[i]});
    fwd = 1'b0;
`ifdef C2C_FWD_EN
    fwd = (t_msg[e_win][15:14] != 2'b10) && (sup != 16'h0);
`endif
    if (t_msg[e_win][15:14] == 2'b10) e_blk = 16'h0;
    else if (fwd) e_blk = sup;
    else begin
      e_blk = t_rdata;
      e_acc.push_back({1'b1, 12'h000, t_msg[e_win][13:10]});
    end
    e_gcyc = e_scyc + e_acc.size() * (t_delay + 1) + 1;
  endtask

  // Drives one transaction, plays the memory with t_delay wait cycles, records outputs.
  task automatic run_txn();
    int         wait_cnt;
    logic [2:0] eg;
    predict();
    eg          = 3'b001 << e_win;
    req_msg     = {t_msg[2], t_msg[1], t_msg[0]};
    wb_req      = t_wbreq;
    wb_block    = {t_wbblk[2], t_wbblk[1], t_wbblk[0]};
    snoop_done  = t_done;
    has_block   = t_has;
    snoop_block = {t_sblk[2], t_sblk[1], t_sblk[0]};
    mem_rdata   = t_rdata;
    mem_ack     = 1'b0;
    req         = t_req;
    o_win = -1; o_gcyc = 0; o_scyc = 0; o_acc.delete(); o_done = 1'b0;
    o_gnt_bad = 1'b0; o_both = 1'b0; o_bus_bad = 1'b0; o_tag_bad = 1'b0;
    o_blk = 16'h0; o_shared = 1'b0; o_resp_bus = 16'h0; o_snoop_bus = 16'h0;
    wait_cnt = 0;
    for (int cyc = 0; cyc < 400 && !o_done; cyc++) begin
      @(negedge clock);
      mem_ack = 1'b0;
      if (gnt != 3'b000) begin
        if (o_win < 0) for (int i = 0; i < 3; i++) if (gnt == (3'b001 << i)) o_win = i;
        o_gcyc++;
        if (o_gcyc == 1) o_snoop_bus = bus_out;
        if (gnt !== eg) o_gnt_bad = 1'b1;
        if (!resp_valid && bus_out !== t_msg[e_win]) o_bus_bad = 1'b1;
        if (!resp_valid && !mem_rd && !mem_wr) o_scyc++;
      end else if (busy) o_gnt_bad = 1'b1;
      if (mem_rd && mem_wr) o_both = 1'b1;
      if (mem_wr && mem_addr_tag !== mem_wdata[15:12]) o_tag_bad = 1'b1;
      if (mem_rd || mem_wr) begin
        if (wait_cnt >= t_delay) begin
          mem_ack  = 1'b1;
          wait_cnt = 0;
          o_acc.push_back(mem_rd ? {1'b1, 12'h000, mem_addr_tag} : {1'b0, mem_wdata});
        end else wait_cnt++;
      end
      if (resp_valid) begin
        o_done = 1'b1; o_blk = resp_block; o_shared = resp_shared; o_resp_bus = bus_out;
        req = 3'b000;
      end
    end
    @(negedge clock);
    mem_ack    = 1'b0;
    o_idle_bad = busy | (gnt != 3'b000) | resp_valid;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 3'b000; req_msg = '0; wb_req = '0; wb_block = '0;
    snoop_done = '0; has_block = '0; snoop_block = '0; mem_rdata = '0; mem_ack = 1'b0;
    m_ptr = 0;
    #1;
    n_checks++;
    if ({gnt, bus_out, mem_rd, mem_wr, mem_addr_tag, mem_wdata, resp_valid, resp_block, resp_shared, busy} !== '0)
      $display("FAIL reset_outputs: gnt=%b bus=%h rd=%b wr=%b busy=%b, all required 0", gnt, bus_out, mem_rd, mem_wr, busy);
    else n_pass++;
    @(negedge clock); reset = 1'b0;
    @(negedge clock);
    n_checks++;
    if ({gnt, busy, mem_rd, mem_wr, resp_valid} !== '0)
      $display("FAIL idle_after_reset: gnt=%b busy=%b rd=%b wr=%b rv=%b, required 0", gnt, busy, mem_rd, mem_wr, resp_valid);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    int exp_order[4] = '{0, 1, 2, 0};
    for (int n = 0; n < 4; n++) begin
      clear_stim();
      t_req = 3'b111; t_rdata = 16'h1000 + 16'(n);
      for (int i = 0; i < 3; i++) t_msg[i] = 16'h0401 + 16'(i);
      run_txn();
      n_checks++;
      if (o_win !== exp_order[n]) $display("FAIL rr_order%0d: granted P%0d, required P%0d", n, o_win, exp_order[n]);
      else n_pass++;
      n_checks++;
      if (o_gnt_bad !== 1'b0) $display("FAIL rr_onehot%0d: gnt not the one-hot P%0d grant throughout", n, exp_order[n]);
      else n_pass++;
    end
  endtask

  task automatic test_read_miss();
    clear_stim();
    t_req = 3'b100; t_msg[2] = 16'h2800; t_rdata = 16'hA80B;
    run_txn();
    n_checks++;
    if (o_snoop_bus !== 16'h2800) $display("FAIL rd_bus_out: got %h, required 2800", o_snoop_bus);
    else n_pass++;
    n_checks++;
    if (o_acc.size() != 1 || o_acc[0] !== {1'b1, 12'h000, 4'hA})
      $display("FAIL rd_mem_access: %0d accesses, first %h, required one read of tag A", o_acc.size(), o_acc.size() ? o_acc[0] : 17'h0);
    else n_pass++;
    n_checks++;
    if (o_blk !== 16'hA80B || o_shared !== 1'b0)
      $display("FAIL rd_resp: block=%h shared=%b, required A80B/0", o_blk, o_shared);
    else n_pass++;
    n_checks++;
    if (o_gcyc != 3) $display("FAIL rd_latency: %0d grant cycles, required 3", o_gcyc);
    else n_pass++;
  endtask

  task automatic test_write_miss_modified();
    clear_stim();
    t_req = 3'b001; t_msg[0] = 16'h7400; t_has = 3'b010;
    t_sblk[1] = 16'hDC55; t_wbreq = 3'b010; t_wbblk[1] = 16'hDC55; t_rdata = 16'hDC55;
    run_txn();
    n_checks++;
    if (o_acc.size() < 1 || o_acc[0] !== {1'b0, 16'hDC55})
      $display("FAIL wm_writeback: first access %h, required write of DC55", o_acc.size() ? o_acc[0] : 17'h0);
    else n_pass++;
    n_checks++;
`ifdef C2C_FWD_EN
    if (o_acc.size() != 1) $display("FAIL wm_no_read: %0d accesses, required 1 (no mem_rd)", o_acc.size());
`else
    if (o_acc.size() != 2 || o_acc[1] !== {1'b1, 12'h000, 4'hD})
      $display("FAIL wm_read_after_wb: %0d accesses, required write then read of tag D", o_acc.size());
`endif
    else n_pass++;
    n_checks++;
    if (o_blk !== 16'hDC55 || o_shared !== 1'b1)
      $display("FAIL wm_resp: block=%h shared=%b, required DC55/1", o_blk, o_shared);
    else n_pass++;
  endtask

  task automatic test_invalidate();
    clear_stim();
    t_req = 3'b010; t_msg[1] = 16'hB000; t_wbreq = 3'b010; t_wbblk[1] = 16'hB80F;
    t_has = 3'b101; t_rdata = 16'h5555;
    run_txn();
    n_checks++;
    if (o_acc.size() != 1 || o_acc[0] !== {1'b0, 16'hB80F})
      $display("FAIL inv_access: %0d accesses, first %h, required only a write of B80F", o_acc.size(), o_acc.size() ? o_acc[0] : 17'h0);
    else n_pass++;
    n_checks++;
    if (o_blk !== 16'h0000 || o_shared !== 1'b1 || o_resp_bus !== 16'h0)
      $display("FAIL inv_resp: block=%h shared=%b bus=%h, required 0000/1/0000", o_blk, o_shared, o_resp_bus);
    else n_pass++;
  endtask

  task automatic test_snoop_timeout();
    clear_stim();
    t_req = 3'b001; t_msg[0] = 16'h0C01; t_done = 3'b011; t_has = 3'b100;
    t_wbreq = 3'b100; t_wbblk[2] = 16'h3111; t_sblk[2] = 16'h3111; t_rdata = 16'h4242;
    run_txn();
    n_checks++;
    if (o_scyc != 4) $display("FAIL to_snoop_cycles: %0d, required 4", o_scyc);
    else n_pass++;
    n_checks++;
    if (o_shared !== 1'b0 || o_blk !== 16'h4242 || o_acc.size() != 1)
      $display("FAIL to_ignore_missing: shared=%b block=%h accesses=%0d, required 0/4242/1", o_shared, o_blk, o_acc.size());
    else n_pass++;
    t_has = 3'b110;
    t_req = 3'b001;
    run_txn();
    n_checks++;
    if (o_shared !== 1'b1 || o_scyc != 4) $display("FAIL to_responder_shared: shared=%b cycles=%0d, required 1/4", o_shared, o_scyc);
    else n_pass++;
  endtask

  task automatic test_reset_abort();
    bit seen;
    clear_stim();
    req_msg = {16'h0001, 16'h0001, 16'h2401}; wb_req = 3'b000; snoop_done = 3'b111;
    has_block = 3'b000; snoop_block = '0; mem_ack = 1'b0; req = 3'b001;
    seen = 1'b0;
    for (int cyc = 0; cyc < 50 && !seen; cyc++) begin
      @(negedge clock);
      if (mem_rd) seen = 1'b1;
    end
    n_checks++;
    if (!seen) $display("FAIL abort_mem_rd: mem_rd never rose within 50 cycles, required 1");
    else n_pass++;
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({mem_rd, gnt, busy} !== 5'b0) $display("FAIL abort_outputs: rd=%b gnt=%b busy=%b, required 0", mem_rd, gnt, busy);
    else n_pass++;
    req = 3'b000;
    @(negedge clock); reset = 1'b0; m_ptr = 0;
    clear_stim();
    t_req = 3'b100; t_msg[2] = 16'h1801; t_rdata = 16'h6006;
    run_txn();
    n_checks++;
    if (o_win !== 2 || o_blk !== 16'h6006 || !o_done)
      $display("FAIL abort_next: winner P%0d block=%h done=%b, required P2/6006/1", o_win, o_blk, o_done);
    else n_pass++;
  endtask

  task automatic test_random();
    bit acc_ok;
    for (int n = 0; n < 25; n++) begin
      clear_stim();
      t_req   = 3'($urandom_range(1, 7));
      t_wbreq = 3'($urandom_range(0, 7));
      t_has   = 3'($urandom_range(0, 7));
      for (int i = 0; i < 3; i++) begin
        t_done[i] = ($urandom_range(0, 3) != 0);
        t_msg[i]  = {2'($urandom_range(0, 2)), 4'($urandom), 10'($urandom) | 10'h1};
        t_wbblk[i] = 16'($urandom);
        t_sblk[i]  = ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'h0;
      end
      t_rdata = 16'($urandom);
      t_delay = $urandom_range(0, 3);
      run_txn();
      n_checks++;
      if (!o_done) begin
        $display("FAIL rand%0d_timeout: no resp_valid within 400 cycles", n);
        continue;
      end else n_pass++;
      n_checks++;
      if (o_win !== e_win || o_gcyc != e_gcyc || o_scyc != e_scyc)
        $display("FAIL rand%0d_timing: P%0d gcyc=%0d scyc=%0d, required P%0d %0d %0d", n, o_win, o_gcyc, o_scyc, e_win, e_gcyc, e_scyc);
      else n_pass++;
      acc_ok = (o_acc.size() == e_acc.size());
      if (acc_ok) foreach (e_acc[i]) if (o_acc[i] !== e_acc[i]) acc_ok = 1'b0;
      n_checks++;
      if (!acc_ok) $display("FAIL rand%0d_mem_seq: %0d accesses first %h, required %0d first %h", n,
                            o_acc.size(), o_acc.size() ? o_acc[0] : 17'h0, e_acc.size(), e_acc.size() ? e_acc[0] : 17'h0);
      else n_pass++;
      n_checks++;
      if (o_blk !== e_blk || o_shared !== e_shared || o_resp_bus !== 16'h0)
        $display("FAIL rand%0d_resp: block=%h shared=%b bus=%h, required %h/%b/0000", n, o_blk, o_shared, o_resp_bus, e_blk, e_shared);
      else n_pass++;
      n_checks++;
      if ({o_gnt_bad, o_both, o_bus_bad, o_tag_bad, o_idle_bad} !== 5'b0)
        $display("FAIL rand%0d_protocol: gnt=%b both=%b bus=%b tag=%b idle=%b, required all 0", n,
                 o_gnt_bad, o_both, o_bus_bad, o_tag_bad, o_idle_bad);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_read_miss();
    test_write_miss_modified();
    test_invalidate();
    test_snoop_timeout();
    test_reset_abort();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
